// File: rtl/invalidation_merge_queue.sv
// Multi-source instruction-invalidation queue: round-robin intake,
// line-granular coalescing, first-word-fall-through delivery to one sink.
module invalidation_merge_queue #(
  parameter int NUM_SOURCES      = 2,
  parameter int DEPTH            = 4,
  parameter int ADDR_WIDTH       = 32,
  parameter int LINE_OFFSET_BITS = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SOURCES*ADDR_WIDTH-1:0] src_inv_addr,
  input  logic [NUM_SOURCES-1:0]            src_inv_valid,
  output logic [NUM_SOURCES-1:0]            src_inv_ready,
  output logic [ADDR_WIDTH-1:0]             sink_inv_addr,
  output logic                              sink_inv_valid,
  input  logic                              sink_inv_ready,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic [15:0]                       coalesced_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int LW = ADDR_WIDTH - LINE_OFFSET_BITS;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (NUM_SOURCES < 1 || NUM_SOURCES > 8) begin : g_bad_src
    $error("NUM_SOURCES must be 1..8");
  end

  logic [LW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic [SW-1:0] rr_ptr;
  logic [15:0]   coal;

  logic          found;
  logic [SW-1:0] grant;
  logic [SW-1:0] next_rr;
  logic          full;
  logic          push;
  logic          pop;
  logic          dup;
  logic          store;
  logic [LW-1:0] in_line;

  // First requesting source at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      if (!found &&
          src_inv_valid[(int'(rr_ptr) + k) % NUM_SOURCES]) begin
        found = 1'b1;
        grant = SW'((int'(rr_ptr) + k) % NUM_SOURCES);
      end
    end
  end

  assign next_rr = SW'((int'(grant) + 1) % NUM_SOURCES);
  assign full    = (cnt == CW'(DEPTH));
  assign push    = rst && found && !full;
  assign pop     = sink_inv_valid && sink_inv_ready;
  assign store   = push && !dup;

  always_comb begin
    src_inv_ready = '0;
    if (push) begin
      src_inv_ready[grant] = 1'b1;
    end
  end

  assign in_line = src_inv_addr[int'(grant)*ADDR_WIDTH
                                + LINE_OFFSET_BITS +: LW];

  // Live entries are those within cnt of the head; a departing head
  // must not absorb a new request for its own line.
  always_comb begin
    logic [PW-1:0] off;
    logic          live;
    off  = '0;
    live = 1'b0;
    dup  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off  = PW'(i) - rd_ptr;
      live = (CW'(off) < cnt) && !(pop && off == '0);
      if (live && mem[i] == in_line) begin
        dup = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      rr_ptr <= '0;
      coal   <= '0;
    end else begin
      if (push) begin
        rr_ptr <= next_rr;
      end
      if (push && dup && coal != 16'hFFFF) begin
        coal <= coal + 16'd1;
      end
      if (store) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      cnt <= cnt + CW'(store) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= in_line;
    end
  end

  assign sink_inv_addr   = {mem[rd_ptr], {LINE_OFFSET_BITS{1'b0}}};
  assign sink_inv_valid  = (cnt != '0);
  assign count           = cnt;
  assign coalesced_count = coal;

endmodule
